// File: rtl/demux_1to32_capture.sv
// demux_1to32_capture
// Bit-serial to word capture: single bits are steered into a capture word
// (by sel, or by an internal pointer when AUTO_INC=1) and the finished word
// is handed to the consumer with a valid/ready handshake.
module demux_1to32_capture #(
   parameter int N        = 32,
   parameter int SW       = 5,
   parameter int AUTO_INC = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          e,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          d,
   input  logic [SW-1:0] sel,
   input  logic          last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_word,
   output logic [N-1:0]  out_mask,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [N-1:0]  word, word_n;
   logic [N-1:0]  mask, mask_n;
   logic [N-1:0]  bitsel;
   logic [SW-1:0] ptr, ptr_n;
   logic [SW-1:0] idx;
   logic          accept;
   logic          in_range;
   logic          done;

   assign in_ready = e & (state != HOLD);
   assign accept   = in_valid & in_ready;
   assign busy     = (state != IDLE);
   assign idx      = (AUTO_INC != 0) ? ptr : sel;
   assign in_range = ({1'b0, idx} < (SW+1)'(N));
   // one-hot write strobe; an out-of-range index writes nothing
   assign bitsel   = in_range ? (N'(1) << idx) : '0;

   // next-state and next-word computation
   always_comb begin
      state_n = state;
      word_n  = word;
      mask_n  = mask;
      ptr_n   = ptr;
      done    = 1'b0;
      case (state)
         IDLE, FILL: begin
            if (accept) begin
               word_n  = d ? (word | bitsel) : (word & ~bitsel);
               mask_n  = mask | bitsel;
               if (AUTO_INC != 0)
                  ptr_n = ptr + SW'(1);
               done    = last | (&mask_n) |
                         ((AUTO_INC != 0) && (ptr == SW'(N-1)));
               state_n = done ? HOLD : FILL;
            end
         end
         HOLD: begin
            if (out_ready) begin
               word_n  = '0;
               mask_n  = '0;
               ptr_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // capture registers and registered outputs (outputs zero outside HOLD)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word      <= '0;
         mask      <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_mask  <= '0;
      end else begin
         word      <= word_n;
         mask      <= mask_n;
         ptr       <= ptr_n;
         out_valid <= (state_n == HOLD);
         out_word  <= (state_n == HOLD) ? word_n : '0;
         out_mask  <= (state_n == HOLD) ? mask_n : '0;
      end
   end

endmodule

// File: tb/tb_demux_1to32_capture.sv
// tb_demux_1to32_capture
// Self-checking bench: dut0 uses sel addressing, dut1 uses the auto pointer.
// Expected words come from a per-instance bit-array model.
module tb_demux_1to32_capture;

   logic        clk = 1'b0;
   logic        rst;

   logic        e0, iv0, d0, l0, or0;
   logic [4:0]  s0;
   logic        ir0, ov0, bz0;
   logic [31:0] ow0, om0;

   logic        e1, iv1, d1, l1, or1;
   logic [4:0]  s1;
   logic        ir1, ov1, bz1;
   logic [31:0] ow1, om1;

   int          checks = 0;
   int          fails  = 0;
   int          tmo    = 0;

   logic [31:0] mw [2];
   logic [31:0] mm [2];
   int          pcnt [2];

   demux_1to32_capture #(.N(32), .SW(5), .AUTO_INC(0)) dut0 (
      .clk(clk), .rst(rst), .e(e0), .in_valid(iv0), .in_ready(ir0),
      .d(d0), .sel(s0), .last(l0), .out_valid(ov0), .out_ready(or0),
      .out_word(ow0), .out_mask(om0), .busy(bz0)
   );

   demux_1to32_capture #(.N(32), .SW(5), .AUTO_INC(1)) dut1 (
      .clk(clk), .rst(rst), .e(e1), .in_valid(iv1), .in_ready(ir1),
      .d(d1), .sel(s1), .last(l1), .out_valid(ov1), .out_ready(or1),
      .out_word(ow1), .out_mask(om1), .busy(bz1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic rdy(input int u);
      return (u == 0) ? ir0 : ir1;
   endfunction

   function automatic logic ovf(input int u);
      return (u == 0) ? ov0 : ov1;
   endfunction

   function automatic logic bzf(input int u);
      return (u == 0) ? bz0 : bz1;
   endfunction

   task automatic model_clear(input int u);
      mw[u]   = '0;
      mm[u]   = '0;
      pcnt[u] = 0;
   endtask

   task automatic drive(input int u, input logic v, input logic dv,
                        input logic [4:0] s, input logic lv);
      if (u == 0) begin
         iv0 = v; d0 = dv; s0 = s; l0 = lv;
      end else begin
         iv1 = v; d1 = dv; s1 = s; l1 = lv;
      end
   endtask

   // offer one bit, wait (bounded) for acceptance, update the model;
   // done = model says the word is complete, ovs = out_valid right after
   task automatic send(input int u, input logic dv, input logic [4:0] s,
                       input logic lv, output logic done, output logic ovs);
      int cnt;
      int idx;
      cnt = 0;
      drive(u, 1'b1, dv, s, lv);
      #1;
      while (!rdy(u) && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (cnt >= 100) tmo++;
      @(posedge clk); #1;
      drive(u, 1'b0, 1'b0, 5'd0, 1'b0);
      idx = (u == 1) ? pcnt[1] : int'(s);
      mw[u][idx] = dv;
      mm[u][idx] = 1'b1;
      pcnt[u]++;
      done = lv | (&mm[u]);
      ovs  = ovf(u);
   endtask

   // wait for out_valid, optionally stall, then take the word
   task automatic recv(input int u, input int dly, output logic [31:0] w,
                       output logic [31:0] m, output logic ova,
                       output logic bza);
      int cnt;
      cnt = 0;
      while (!ovf(u) && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (cnt >= 100) tmo++;
      for (int k = 0; k < dly; k++) begin
         @(posedge clk); #1;
      end
      w = (u == 0) ? ow0 : ow1;
      m = (u == 0) ? om0 : om1;
      if (u == 0) or0 = 1'b1; else or1 = 1'b1;
      @(posedge clk); #1;
      if (u == 0) or0 = 1'b0; else or1 = 1'b0;
      ova = ovf(u);
      bza = bzf(u);
      model_clear(u);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      checks += 10;
      if (ov0 !== 1'b0) begin fails++; $display("FAIL rst_ov0: got %b want 0", ov0); end
      if (ir0 !== 1'b0) begin fails++; $display("FAIL rst_ir0: got %b want 0", ir0); end
      if (bz0 !== 1'b0) begin fails++; $display("FAIL rst_bz0: got %b want 0", bz0); end
      if (ow0 !== 32'h0) begin fails++; $display("FAIL rst_ow0: got %h want 0", ow0); end
      if (om0 !== 32'h0) begin fails++; $display("FAIL rst_om0: got %h want 0", om0); end
      if (ov1 !== 1'b0) begin fails++; $display("FAIL rst_ov1: got %b want 0", ov1); end
      if (ir1 !== 1'b0) begin fails++; $display("FAIL rst_ir1: got %b want 0", ir1); end
      if (bz1 !== 1'b0) begin fails++; $display("FAIL rst_bz1: got %b want 0", bz1); end
      if (ow1 !== 32'h0) begin fails++; $display("FAIL rst_ow1: got %h want 0", ow1); end
      if (om1 !== 32'h0) begin fails++; $display("FAIL rst_om1: got %h want 0", om1); end
      @(negedge clk);
      rst = 1'b0;
      e0 = 1'b1;
      e1 = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sweep;
      logic done, ovs, ova, bza;
      logic [31:0] w, m;
      for (int i = 0; i < 32; i++) begin
         send(0, i[0], i[4:0], 1'b0, done, ovs);
         checks++;
         if (ovs !== (i == 31)) begin
            fails++;
            $display("FAIL sweep_valid bit %0d: got %b want %b", i, ovs, (i == 31));
         end
      end
      recv(0, 0, w, m, ova, bza);
      checks += 4;
      if (w !== 32'hAAAAAAAA) begin fails++; $display("FAIL sweep_word: got %h want aaaaaaaa", w); end
      if (m !== 32'hFFFFFFFF) begin fails++; $display("FAIL sweep_mask: got %h want ffffffff", m); end
      if (ova !== 1'b0) begin fails++; $display("FAIL sweep_handoff_valid: got %b want 0", ova); end
      if (bza !== 1'b0) begin fails++; $display("FAIL sweep_handoff_busy: got %b want 0", bza); end
   endtask

   task automatic test_hold;
      logic done, ovs, ova, bza;
      logic [31:0] w, m;
      send(0, 1'b1, 5'd5, 1'b0, done, ovs);
      send(0, 1'b1, 5'd9, 1'b1, done, ovs);
      checks++;
      if (ovs !== 1'b1) begin fails++; $display("FAIL hold_latency: got %b want 1", ovs); end
      drive(0, 1'b1, 1'b1, 5'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks += 3;
         if (ir0 !== 1'b0) begin fails++; $display("FAIL hold_in_ready: got %b want 0", ir0); end
         if (ow0 !== 32'h00000220) begin fails++; $display("FAIL hold_word: got %h want 00000220", ow0); end
         if (om0 !== 32'h00000220) begin fails++; $display("FAIL hold_mask: got %h want 00000220", om0); end
      end
      drive(0, 1'b0, 1'b0, 5'd0, 1'b0);
      recv(0, 0, w, m, ova, bza);
      checks += 3;
      if (w !== 32'h00000220) begin fails++; $display("FAIL hold_rx_word: got %h want 00000220", w); end
      if (ova !== 1'b0) begin fails++; $display("FAIL hold_bubble_valid: got %b want 0", ova); end
      if (ir0 !== 1'b1) begin fails++; $display("FAIL hold_bubble_ready: got %b want 1", ir0); end
   endtask

   task automatic test_rewrite;
      logic done, ovs, ova, bza;
      logic [31:0] w, m;
      send(0, 1'b1, 5'd3, 1'b0, done, ovs);
      send(0, 1'b0, 5'd3, 1'b1, done, ovs);
      recv(0, 1, w, m, ova, bza);
      checks += 2;
      if (w !== 32'h0) begin fails++; $display("FAIL rewrite_word: got %h want 0", w); end
      if (m !== 32'h00000008) begin fails++; $display("FAIL rewrite_mask: got %h want 00000008", m); end
   endtask

   task automatic test_single_bit;
      logic done, ovs, ova, bza;
      logic [31:0] w, m;
      send(0, 1'b1, 5'd31, 1'b1, done, ovs);
      checks++;
      if (ovs !== 1'b1) begin fails++; $display("FAIL single_latency: got %b want 1", ovs); end
      recv(0, 0, w, m, ova, bza);
      checks += 2;
      if (w !== 32'h80000000) begin fails++; $display("FAIL single_word: got %h want 80000000", w); end
      if (m !== 32'h80000000) begin fails++; $display("FAIL single_mask: got %h want 80000000", m); end
      send(1, 1'b1, 5'd17, 1'b1, done, ovs);
      recv(1, 0, w, m, ova, bza);
      checks += 2;
      if (w !== 32'h1) begin fails++; $display("FAIL single_ai_word: got %h want 1", w); end
      if (m !== 32'h1) begin fails++; $display("FAIL single_ai_mask: got %h want 1", m); end
   endtask

   task automatic test_autoinc;
      logic done, ovs, ova, bza;
      logic [31:0] w, m, pat;
      pat = 32'hDEADBEEF;
      for (int i = 0; i < 32; i++)
         send(1, pat[i], 5'($urandom), 1'b0, done, ovs);
      checks++;
      if (ovs !== 1'b1) begin fails++; $display("FAIL ai_latency: got %b want 1", ovs); end
      recv(1, 2, w, m, ova, bza);
      checks += 4;
      if (w !== 32'hDEADBEEF) begin fails++; $display("FAIL ai_word: got %h want deadbeef", w); end
      if (m !== 32'hFFFFFFFF) begin fails++; $display("FAIL ai_mask: got %h want ffffffff", m); end
      if (dut1.ptr !== 5'd0) begin fails++; $display("FAIL ai_ptr: got %0d want 0", dut1.ptr); end
      if (ova !== 1'b0) begin fails++; $display("FAIL ai_handoff_valid: got %b want 0", ova); end
   endtask

   task automatic test_enable;
      logic done, ovs, ova, bza;
      logic [31:0] w, m, expw, expm;
      for (int i = 0; i < 10; i++)
         send(0, 1'($urandom), i[4:0], 1'b0, done, ovs);
      e0 = 1'b0;
      drive(0, 1'b1, 1'b1, 5'd20, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks += 3;
         if (ir0 !== 1'b0) begin fails++; $display("FAIL en_in_ready: got %b want 0", ir0); end
         if (dut0.mask !== mm[0]) begin fails++; $display("FAIL en_mask: got %h want %h", dut0.mask, mm[0]); end
         if (ov0 !== 1'b0) begin fails++; $display("FAIL en_valid: got %b want 0", ov0); end
      end
      drive(0, 1'b0, 1'b0, 5'd0, 1'b0);
      e0 = 1'b1;
      for (int i = 10; i < 32; i++)
         send(0, 1'($urandom), i[4:0], 1'b0, done, ovs);
      expw = mw[0];
      expm = mm[0];
      recv(0, 0, w, m, ova, bza);
      checks += 2;
      if (w !== expw) begin fails++; $display("FAIL en_word: got %h want %h", w, expw); end
      if (m !== expm) begin fails++; $display("FAIL en_mask_final: got %h want %h", m, expm); end
   endtask

   task automatic test_reset_midword;
      logic done, ovs, ova, bza;
      logic [31:0] w, m;
      for (int i = 0; i < 10; i++)
         send(0, 1'b1, 5'(i + 16), 1'b0, done, ovs);
      rst = 1'b1;
      #1;
      checks += 3;
      if (ov0 !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", ov0); end
      if (dut0.mask !== 32'h0) begin fails++; $display("FAIL rmid_mask: got %h want 0", dut0.mask); end
      if (bz0 !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", bz0); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      model_clear(0);
      model_clear(1);
      send(0, 1'b1, 5'd7, 1'b0, done, ovs);
      send(0, 1'b1, 5'd12, 1'b1, done, ovs);
      recv(0, 0, w, m, ova, bza);
      checks += 2;
      if (w !== 32'h00001080) begin fails++; $display("FAIL rmid_word: got %h want 00001080", w); end
      if (m !== 32'h00001080) begin fails++; $display("FAIL rmid_mask_new: got %h want 00001080", m); end
   endtask

   task automatic test_random;
      logic done, ovs, ova, bza;
      logic [31:0] w, m, expw, expm;
      int nb;
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 6; n++) begin
            nb = 0;
            done = 1'b0;
            while (!done && nb < 300) begin
               for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                  @(posedge clk); #1;
               end
               send(u, 1'($urandom), 5'($urandom), ($urandom_range(0, 15) == 0),
                    done, ovs);
               nb++;
               checks++;
               if (ovs !== done) begin
                  fails++;
                  $display("FAIL rand_valid u%0d word %0d bit %0d: got %b want %b", u, n, nb, ovs, done);
               end
            end
            expw = mw[u];
            expm = mm[u];
            recv(u, int'($urandom_range(0, 3)), w, m, ova, bza);
            checks += 3;
            if (w !== expw) begin fails++; $display("FAIL rand_word u%0d: got %h want %h", u, w, expw); end
            if (m !== expm) begin fails++; $display("FAIL rand_mask u%0d: got %h want %h", u, m, expm); end
            if (ova !== 1'b0) begin fails++; $display("FAIL rand_handoff u%0d: got %b want 0", u, ova); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      e0 = 1'b0; iv0 = 1'b0; d0 = 1'b0; s0 = '0; l0 = 1'b0; or0 = 1'b0;
      e1 = 1'b0; iv1 = 1'b0; d1 = 1'b0; s1 = '0; l1 = 1'b0; or1 = 1'b0;
      model_clear(0);
      model_clear(1);
      test_reset();
      test_sweep();
      test_hold();
      test_rewrite();
      test_single_bit();
      test_autoinc();
      test_enable();
      test_reset_midword();
      test_random();
      checks++;
      if (tmo !== 0) begin
         fails++;
         $display("FAIL handshake_timeout: got %0d expired waits want 0", tmo);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
